// File: rtl/mux_scan.sv
// mux_scan: registered channel mux with manual select or round-robin scan,
// feeding a one-word valid/ready output slot.
module mux_scan #(
  parameter int WIDTH = 8,
  parameter int CH = 4,
  localparam int SELW = (CH > 2) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] din,
  input  logic [CH-1:0]       din_vld,
  output logic [CH-1:0]       din_ack,
  input  logic [SELW-1:0]     sel,
  input  logic                mode,
  output logic [WIDTH-1:0]    y,
  output logic [SELW-1:0]     y_ch,
  output logic                y_vld,
  input  logic                y_rdy
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0] r_y_ch, r_ptr;
  logic [CH-1:0] r_ack;
  logic w_free, w_cap, w_rr_hit, w_man_hit;
  logic [SELW-1:0] w_rr_grant, w_grant, w_next_ptr;
  logic [SELW:0] w_idx;
  logic [WIDTH-1:0] w_data;
  logic [CH-1:0] w_onehot;
  // Scan downward so the channel closest to ptr (in wrap order) wins last.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_grant = '0;
    w_idx = '0;
    w_man_hit = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (SELW+1)'(i);
      if (w_idx >= (SELW+1)'(CH)) w_idx = w_idx - (SELW+1)'(CH);
      if (din_vld[w_idx[SELW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_grant = w_idx[SELW-1:0];
      end
    end
    for (int k = 0; k < CH; k++)
      if (SELW'(k) == sel && din_vld[k]) w_man_hit = 1'b1;
  end
  assign w_free = (r_state == EMPTY) || y_rdy;
  assign w_grant = mode ? w_rr_grant : sel;
  assign w_cap = w_free && (mode ? w_rr_hit : w_man_hit);
  assign w_next_ptr = (w_grant == SELW'(CH - 1)) ? '0 : w_grant + SELW'(1);
  always_comb begin
    w_data = '0;
    w_onehot = '0;
    for (int k = 0; k < CH; k++) begin
      w_onehot[k] = (SELW'(k) == w_grant);
      if (SELW'(k) == w_grant) w_data = din[k*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_y <= '0;
      r_y_ch <= '0;
      r_ack <= '0;
      r_ptr <= '0;
    end else begin
      r_ack <= w_cap ? w_onehot : '0;
      if (w_cap) begin
        r_state <= FULL;
        r_y <= w_data;
        r_y_ch <= w_grant;
        if (mode) r_ptr <= w_next_ptr;
      end else if (w_free) begin
        r_state <= EMPTY;
      end
    end
  end
  assign y = r_y;
  assign y_ch = r_y_ch;
  assign y_vld = (r_state == FULL);
  assign din_ack = r_ack;
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed and randomized checks of mux_scan against a
// behavioural model of the output slot and round-robin pointer.
module tb_mux_scan;
  localparam int W = 8;
  localparam int C = 4;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [C*W-1:0] din;
  logic [C-1:0] din_vld, din_ack;
  logic [SW-1:0] sel, y_ch;
  logic mode, y_vld, y_rdy;
  logic [W-1:0] y;
  logic [23:0] din3;
  logic [2:0] vld3, ack3;
  logic [1:0] sel3, ych3;
  logic [7:0] y3;
  logic yv3, rdy3;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  mux_scan #(.WIDTH(W), .CH(C)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_ack(din_ack),
    .sel(sel), .mode(mode), .y(y), .y_ch(y_ch), .y_vld(y_vld), .y_rdy(y_rdy)
  );
  mux_scan #(.WIDTH(8), .CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .din_vld(vld3), .din_ack(ack3),
    .sel(sel3), .mode(1'b0), .y(y3), .y_ch(ych3), .y_vld(yv3), .y_rdy(rdy3)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // Reference model: one-word slot, arbitration by explicit modular search.
  logic [W-1:0] m_y = '0;
  logic [SW-1:0] m_ch = '0;
  logic m_vld = 1'b0;
  logic [C-1:0] m_ack = '0;
  int m_ptr = 0;
  always @(posedge clk or negedge rst_n) begin
    int g, s, idx;
    bit f;
    if (!rst_n) begin
      m_y = '0; m_ch = '0; m_vld = 1'b0; m_ack = '0; m_ptr = 0;
    end else begin
      m_ack = '0;
      if (!m_vld || y_rdy) begin
        f = 1'b0;
        g = 0;
        if (!mode) begin
          s = int'(sel);
          if (s < C && ((din_vld >> s) & 4'd1) != 4'd0) begin g = s; f = 1'b1; end
        end else begin
          for (int i = 0; i < C; i++) begin
            idx = (m_ptr + i) % C;
            if (!f && ((din_vld >> idx) & 4'd1) != 4'd0) begin g = idx; f = 1'b1; end
          end
        end
        if (f) begin
          m_y = W'(din >> (g * W));
          m_ch = SW'(g);
          m_vld = 1'b1;
          m_ack = C'(1 << g);
          if (mode) m_ptr = (g + 1) % C;
        end else m_vld = 1'b0;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("model_vld", 32'(y_vld), 32'(m_vld));
    chk("model_ack", 32'(din_ack), 32'(m_ack));
    if (m_vld) begin
      chk("model_y", 32'(y), 32'(m_y));
      chk("model_ch", 32'(y_ch), 32'(m_ch));
    end
  end
  initial begin
    din = '0; din_vld = '0; sel = '0; mode = 1'b0; y_rdy = 1'b0;
    din3 = '0; vld3 = '0; sel3 = '0; rdy3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_ych", 32'(y_ch), 32'h0);
    chk("rst_vld", 32'(y_vld), 32'h0);
    chk("rst_ack", 32'(din_ack), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    sel3 = 2'd3; vld3 = 3'b111; din3 = 24'hCCBBAA; rdy3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("oor_vld", 32'(yv3), 32'h0);
    chk("oor_ack", 32'(ack3), 32'h0);
    @(negedge clk) sel3 = 2'd2;
    @(posedge clk);
    #1 chk("ch3_y", 32'(y3), 32'hCC);
    chk("ch3_ych", 32'(ych3), 32'h2);
    chk("ch3_ack", 32'(ack3), 32'h4);
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; din = 32'h00A50000; din_vld = 4'b0100; y_rdy = 1'b1;
    @(posedge clk);
    #1 chk("man_y", 32'(y), 32'hA5);
    chk("man_ych", 32'(y_ch), 32'h2);
    chk("man_vld", 32'(y_vld), 32'h1);
    chk("man_ack", 32'(din_ack), 32'h4);
    @(negedge clk) begin sel = 2'd1; din = 32'h00001100; din_vld = 4'b0010; end
    @(posedge clk);
    #1 chk("bp_load", 32'(y), 32'h11);
    @(negedge clk) begin y_rdy = 1'b0; din = 32'h00002200; end
    repeat (3) begin
      @(posedge clk);
      #1 chk("bp_hold_y", 32'(y), 32'h11);
      chk("bp_hold_ack", 32'(din_ack), 32'h0);
    end
    @(negedge clk) y_rdy = 1'b1;
    @(posedge clk);
    #1 chk("bp_release_y", 32'(y), 32'h22);
    chk("bp_release_ack", 32'(din_ack), 32'h2);
    @(negedge clk) begin mode = 1'b1; din = 32'h44332211; din_vld = 4'hF; end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 chk("rr_ch", 32'(y_ch), 32'(i % 4));
      chk("rr_ack", 32'(din_ack), 32'(1 << (i % 4)));
    end
    @(negedge clk) din_vld = 4'b0100;
    @(posedge clk);
    #1 chk("wrap_set", 32'(y_ch), 32'h2);
    @(negedge clk) din_vld = 4'b0010;
    @(posedge clk);
    #1 chk("wrap_skip", 32'(y_ch), 32'h1);
    @(negedge clk) din_vld = 4'b0000;
    @(posedge clk);
    #1 chk("drain_vld", 32'(y_vld), 32'h0);
    @(negedge clk) din_vld = 4'hF;
    @(posedge clk);
    #1 chk("ptr_after_skip", 32'(y_ch), 32'h2);
    @(negedge clk) din_vld = 4'b0100;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_vld", 32'(y_vld), 32'h0);
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_ack", 32'(din_ack), 32'h0);
    chk("arst_ych", 32'(y_ch), 32'h0);
    @(negedge clk) begin rst_n = 1'b1; din_vld = 4'hF; end
    @(posedge clk);
    #1 chk("arst_restart", 32'(y_ch), 32'h0);
    repeat (400) begin
      @(negedge clk);
      mode = 1'($urandom);
      sel = SW'($urandom);
      din = $urandom;
      din_vld = C'($urandom);
      y_rdy = ($urandom % 4) != 0;
      if ($urandom % 60 == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
